sha_digest_finalizer: RTL and testbench

Output stage of the super-pipelined SHA-256 core, directly downstream of the last round stage. It performs the SHA-256 feed-forward addition: the final working state plus the chaining value. It tracks that chaining value across the blocks of a multi-block message. Completed digests go into a small output FIFO with a ready/valid handshake, since the round pipeline cannot stall.

---
 rtl/sha_pkg.sv | 37 +++
 rtl/sha_digest_fifo.sv | 58 +++++
 rtl/sha_digest_finalizer.sv | 96 +++++++++
 tb/tb_sha_digest_finalizer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sha_pkg.sv
// rtl/sha_pkg.sv - shared SHA-256 types and constants
// Working-state struct, digest word array and the standard initial hash value.
package sha_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } HashState;

    typedef logic [7:0][31:0] Digest;

    // Element [0] is H0; the packed concatenation lists [7] first.
    localparam Digest SHA256_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };

    function automatic Digest state_words(input HashState s);
        Digest w;
        w[0] = s.a;
        w[1] = s.b;
        w[2] = s.c;
        w[3] = s.d;
        w[4] = s.e;
        w[5] = s.f;
        w[6] = s.g;
        w[7] = s.h;
        return w;
    endfunction

endpackage

// File: rtl/sha_digest_fifo.sv
// rtl/sha_digest_fifo.sv - synchronous FIFO holding completed digests
// A push into a full FIFO is accepted only when a pop retires the head in the same cycle.
module sha_digest_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 256,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level,
    output logic             accepted
);

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      count;
    logic             do_pop;
    logic             do_push;

    assign empty    = (count == '0);
    assign full     = (count == FULL_LEVEL);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign accepted = do_push;
    assign level    = count;
    assign rdata    = mem[rptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop)  rptr <= rptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; entries are only visible once written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/sha_digest_finalizer.sv
// rtl/sha_digest_finalizer.sv - SHA-256 feed-forward add, chaining and digest output FIFO
// Optional digest push counter (count_o) enabled by SHA_FINALIZE_COUNT_EN.
module sha_digest_finalizer
    import sha_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  HashState                      state_i,
    input  logic                          valid_i,
    input  logic                          newblock_i,
    input  logic                          lastblock_i,
    output logic [7:0][31:0]              digest_o,
    output logic                          digest_valid_o,
    input  logic                          digest_ready_i,
    output logic [$clog2(FIFO_DEPTH):0]   level_o,
    output logic                          overflow_o
`ifdef SHA_FINALIZE_COUNT_EN
    ,
    output logic [31:0]                   count_o
`endif
);

    Digest chain;
    Digest base;
    Digest words;
    Digest sum;
    logic  push;
    logic  accepted;
    logic  full;
    logic  empty;
    logic  overflow_q;

    always_comb begin
        words = state_words(state_i);
        base  = newblock_i ? SHA256_IV : chain;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = base[i] + words[i];
        end
    end

    assign push = valid_i && lastblock_i;

    // The chain follows every valid block, whether or not its digest fits in the FIFO.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= SHA256_IV;
        end else if (valid_i) begin
            chain <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow_q <= 1'b0;
        end else if (push && !accepted) begin
            overflow_q <= 1'b1;
        end
    end

    sha_digest_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (256)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wdata    (sum),
        .pop      (digest_ready_i),
        .rdata    (digest_o),
        .full     (full),
        .empty    (empty),
        .level    (level_o),
        .accepted (accepted)
    );

    assign digest_valid_o = !empty;
    assign overflow_o     = overflow_q;

`ifdef SHA_FINALIZE_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else if (accepted) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign count_o = count_q;
`endif

endmodule

// File: tb/tb_sha_digest_finalizer.sv
// tb/tb_sha_digest_finalizer.sv - self-checking bench for sha_digest_finalizer
// Directed blocks against a queue-based model plus hand-computed digests.
module tb_sha_digest_finalizer;
    import sha_pkg::*;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    HashState    state_i = '0;
    logic        valid_i = 1'b0;
    logic        newb = 1'b0;
    logic        last = 1'b0;
    logic        ready = 1'b0;
    Digest       digest_o;
    logic        dv;
    logic [2:0]  level;
    logic        ovf;
`ifdef SHA_FINALIZE_COUNT_EN
    logic [31:0] cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sha_digest_finalizer #(.FIFO_DEPTH(D)) dut (
        .clk            (clk),
        .rst            (rst),
        .state_i        (state_i),
        .valid_i        (valid_i),
        .newblock_i     (newb),
        .lastblock_i    (last),
        .digest_o       (digest_o),
        .digest_valid_o (dv),
        .digest_ready_i (ready),
        .level_o        (level),
        .overflow_o     (ovf)
`ifdef SHA_FINALIZE_COUNT_EN
        ,
        .count_o        (cnt)
`endif
    );

    // Hand-written constants, independent of the package.
    localparam Digest EXP_IV = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
    };
    localparam Digest EXP_IV_PLUS1 = {
        32'h5be0cd1a, 32'h1f83d9ac, 32'h9b05688d, 32'h510e5280,
        32'ha54ff53b, 32'h3c6ef373, 32'hbb67ae86, 32'h6a09e668
    };
    localparam Digest EXP_IV_MINUS1 = {
        32'h5be0cd18, 32'h1f83d9aa, 32'h9b05688b, 32'h510e527e,
        32'ha54ff539, 32'h3c6ef371, 32'hbb67ae84, 32'h6a09e666
    };

    Digest       m_chain = EXP_IV;
    Digest       q[$];
    bit          m_ovf = 1'b0;
    int unsigned m_cnt = 0;
    Digest       cur_w = '0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge clk or negedge rst) begin : model
        bit    popped;
        Digest b;
        Digest s;
        if (!rst) begin
            m_chain = EXP_IV;
            q.delete();
            m_ovf = 1'b0;
            m_cnt = 0;
        end else begin
            popped = 1'b0;
            if (ready && q.size() > 0) begin
                void'(q.pop_front());
                popped = 1'b1;
            end
            if (valid_i) begin
                b = newb ? EXP_IV : m_chain;
                for (int i = 0; i < 8; i++) s[i] = b[i] + cur_w[i];
                m_chain = s;
                if (last) begin
                    if (q.size() < D) begin
                        q.push_back(s);
                        m_cnt++;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        chk("valid", 256'(dv), 256'(q.size() != 0));
        chk("level", 256'(level), 256'(q.size()));
        chk("overflow", 256'(ovf), 256'(m_ovf));
        if (dv && q.size() > 0) chk("digest", digest_o, q[0]);
`ifdef SHA_FINALIZE_COUNT_EN
        chk("count", 256'(cnt), 256'(m_cnt));
`endif
    end

    function automatic Digest mk(input logic [31:0] b);
        Digest w;
        for (int i = 0; i < 8; i++) w[i] = b + 32'(i) * 32'h01010101;
        return w;
    endfunction

    task automatic step(input Digest w, input logic nb, input logic lb, input logic rd);
        @(negedge clk);
        #1;
        cur_w     = w;
        state_i.a = w[0];
        state_i.b = w[1];
        state_i.c = w[2];
        state_i.d = w[3];
        state_i.e = w[4];
        state_i.f = w[5];
        state_i.g = w[6];
        state_i.h = w[7];
        newb    = nb;
        last    = lb;
        ready   = rd;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        newb    = 1'b0;
        last    = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst = 1'b0;
        #2;
        rst = 1'b1;
    endtask

    initial begin
        Digest ones;
        Digest ffs;
        for (int i = 0; i < 8; i++) begin
            ones[i] = 32'h00000001;
            ffs[i]  = 32'hffffffff;
        end

        @(posedge clk);
        #2;
        chk("reset_valid", 256'(dv), 256'(0));
        chk("reset_level", 256'(level), 256'(0));
        chk("reset_overflow", 256'(ovf), 256'(0));
        settle();
        rst = 1'b1;

        // single block, zero state
        step('0, 1'b1, 1'b1, 1'b0);
        settle();
        chk("zero_digest", digest_o, EXP_IV);
        chk("zero_valid", 256'(dv), 256'(1));
        chk("zero_level", 256'(level), 256'(1));
        ready = 1'b1;
        settle();
        chk("zero_drained", 256'(dv), 256'(0));
        ready = 1'b0;

        // two-block chain
        step(ones, 1'b1, 1'b0, 1'b0);
        settle();
        chk("chain_nopush", 256'(level), 256'(0));
        step('0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("chain_digest", digest_o, EXP_IV_PLUS1);
        ready = 1'b1;
        settle();

        // carries discarded, push with ready while empty
        step(ffs, 1'b1, 1'b1, 1'b1);
        settle();
        chk("wrap_digest", digest_o, EXP_IV_MINUS1);
        settle();
        chk("wrap_drained", 256'(level), 256'(0));
        ready = 1'b0;

        // full with simultaneous push and pop
        do_reset();
        for (int k = 0; k < 4; k++) step(mk(32'h10 * 32'(k + 1)), 1'b1, 1'b1, 1'b0);
        step(mk(32'h99), 1'b1, 1'b1, 1'b1);
        ready = 1'b0;
        settle();
        chk("fullpop_level", 256'(level), 256'(4));
        chk("fullpop_overflow", 256'(ovf), 256'(0));
        ready = 1'b1;
        repeat (6) settle();
        chk("fullpop_drained", 256'(level), 256'(0));
        ready = 1'b0;

        // overflow: fifth digest dropped
        do_reset();
        for (int k = 0; k < 5; k++) step(mk(32'h100 + 32'(k)), 1'b1, 1'b1, 1'b0);
        settle();
        chk("ovf_level", 256'(level), 256'(4));
        chk("ovf_flag", 256'(ovf), 256'(1));
`ifdef SHA_FINALIZE_COUNT_EN
        chk("ovf_count", 256'(cnt), 256'(4));
`endif
        ready = 1'b1;
        repeat (6) settle();
        chk("ovf_drained", 256'(dv), 256'(0));
        chk("ovf_sticky", 256'(ovf), 256'(1));
        ready = 1'b0;

        // async reset between two blocks of a message
        step(mk(32'h7), 1'b1, 1'b1, 1'b0);
        step(mk(32'h5), 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", 256'(dv), 256'(0));
        chk("arst_level", 256'(level), 256'(0));
        chk("arst_overflow", 256'(ovf), 256'(0));
        #1;
        rst = 1'b1;
        step('0, 1'b0, 1'b1, 1'b0);
        settle();
        chk("arst_chain_iv", digest_o, EXP_IV);
        ready = 1'b1;
        repeat (3) settle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
